// File: rtl/s_path_pkg.sv
// Shared constants for the S-path select/demux logic.
// The 3:1 S mux and the s_demux_router both decode in_sel with these codes,
// so keep them in one place.
package s_path_pkg;

  localparam int S_DW = 64;

  localparam logic [1:0] SEL_D0  = 2'b00;
  localparam logic [1:0] SEL_D1  = 2'b01;
  localparam logic [1:0] SEL_D2  = 2'b10;
  localparam logic [1:0] SEL_BAD = 2'b11;

  localparam int N_DEST = 3;

endpackage

// File: rtl/s_demux_slot.sv
// One-entry valid/ready output register for a single router destination.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   wr_en       load wr_data this cycle (asserted only when free is high)
//   wr_data     word to load
//   free        slot can take a word this cycle (empty, or draining now)
//   out_data    registered word
//   out_valid   out_data holds an undelivered word
//   out_ready   consumer takes out_data this cycle
module s_demux_slot #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          free,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  // Drain and refill in the same cycle keeps throughput at one word/clk.
  assign free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (wr_en) begin
      out_valid <= 1'b1;
      out_data  <= wr_data;
    end else if (out_ready) begin
      // Data holds its last value after a drain; only valid drops.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/s_demux_router.sv
// Steers one S word per cycle to one of three destinations d0/d1/d2 chosen
// by in_sel. Each destination has its own one-entry register, so a stalled
// destination only blocks words that select it. Select 2'b11 is illegal:
// the word is consumed, dropped, flagged on sel_err and counted in drop_cnt.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_data/in_sel/in_valid/in_ready   input handshake
//   dN_data/dN_valid/dN_ready          destination N output handshake
//   sel_err               one-cycle pulse after an illegal word is dropped
//   drop_cnt              saturating count of dropped words
module s_demux_router
  import s_path_pkg::*;
#(
  parameter int DW    = S_DW,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DW-1:0]    d0_data,
  output logic             d0_valid,
  input  logic             d0_ready,
  output logic [DW-1:0]    d1_data,
  output logic             d1_valid,
  input  logic             d1_ready,
  output logic [DW-1:0]    d2_data,
  output logic             d2_valid,
  input  logic             d2_ready,
  output logic             sel_err,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [N_DEST-1:0] slot_free;
  logic [N_DEST-1:0] slot_wr;
  logic              accept;
  logic              drop;

  // Illegal words are always accepted so a bad select can never wedge the
  // input. in_ready deliberately ignores in_valid.
  always_comb begin
    in_ready = 1'b1;
    case (in_sel)
      SEL_D0:  in_ready = slot_free[0];
      SEL_D1:  in_ready = slot_free[1];
      SEL_D2:  in_ready = slot_free[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign drop   = accept && (in_sel == SEL_BAD);

  always_comb begin
    slot_wr = '0;
    if (accept) begin
      case (in_sel)
        SEL_D0:  slot_wr[0] = 1'b1;
        SEL_D1:  slot_wr[1] = 1'b1;
        SEL_D2:  slot_wr[2] = 1'b1;
        default: slot_wr    = '0;
      endcase
    end
  end

  s_demux_slot #(.DW(DW)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (slot_wr[0]),
    .wr_data   (in_data),
    .free      (slot_free[0]),
    .out_data  (d0_data),
    .out_valid (d0_valid),
    .out_ready (d0_ready)
  );

  s_demux_slot #(.DW(DW)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (slot_wr[1]),
    .wr_data   (in_data),
    .free      (slot_free[1]),
    .out_data  (d1_data),
    .out_valid (d1_valid),
    .out_ready (d1_ready)
  );

  s_demux_slot #(.DW(DW)) u_slot2 (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (slot_wr[2]),
    .wr_data   (in_data),
    .free      (slot_free[2]),
    .out_data  (d2_data),
    .out_valid (d2_valid),
    .out_ready (d2_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      sel_err <= drop;
      // Saturate rather than wrap so a long burst of bad selects is visible.
      if (drop && (drop_cnt != {CNT_W{1'b1}}))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_s_demux_router.sv
module tb_s_demux_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] d0_data, d1_data, d2_data;
  logic        d0_valid, d1_valid, d2_valid;
  logic        d0_ready, d1_ready, d2_ready;
  logic        sel_err;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  s_demux_router dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .d0_data  (d0_data),
    .d0_valid (d0_valid),
    .d0_ready (d0_ready),
    .d1_data  (d1_data),
    .d1_valid (d1_valid),
    .d1_ready (d1_ready),
    .d2_data  (d2_data),
    .d2_valid (d2_valid),
    .d2_ready (d2_ready),
    .sel_err  (sel_err),
    .drop_cnt (drop_cnt)
  );

  // Reference model: per-destination queue of undelivered words, the last
  // word written per destination, and the drop statistics.
  logic [63:0] pend [3][$];
  logic [63:0] m_data [3];
  logic        m_err;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] dut_data(input int n);
    case (n)
      0: return d0_data;
      1: return d1_data;
      default: return d2_data;
    endcase
  endfunction

  function automatic logic dut_valid(input int n);
    case (n)
      0: return d0_valid;
      1: return d1_valid;
      default: return d2_valid;
    endcase
  endfunction

  function automatic logic dest_ready(input int n);
    case (n)
      0: return d0_ready;
      1: return d1_ready;
      default: return d2_ready;
    endcase
  endfunction

  // One clock: check combinational in_ready, advance the model, then check
  // registered outputs just after the edge.
  task automatic cycle();
    logic exp_rdy;
    logic acc;
    #1;
    if (in_sel == 2'b11) exp_rdy = 1'b1;
    else exp_rdy = (pend[in_sel].size() == 0) || dest_ready(int'(in_sel));
    chk("in_ready", in_ready, exp_rdy);
    acc = in_valid && exp_rdy;
    for (int n = 0; n < 3; n++) begin
      if (pend[n].size() != 0 && dest_ready(n)) begin
        chk($sformatf("deliver%0d", n), dut_data(n), pend[n][0]);
        void'(pend[n].pop_front());
      end
    end
    if (rst) begin
      for (int n = 0; n < 3; n++) begin
        pend[n].delete();
        m_data[n] = '0;
      end
      m_err = 1'b0;
      m_cnt = '0;
    end else begin
      m_err = acc && (in_sel == 2'b11);
      if (acc && in_sel != 2'b11) begin
        pend[in_sel].push_back(in_data);
        m_data[in_sel] = in_data;
      end
      if (m_err && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("d%0d_valid", n), dut_valid(n), pend[n].size() != 0);
      chk($sformatf("d%0d_data", n), dut_data(n), m_data[n]);
    end
    chk("sel_err", sel_err, m_err);
    chk("drop_cnt", drop_cnt, m_cnt);
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [63:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  task automatic set_ready(input logic r0, input logic r1, input logic r2);
    d0_ready = r0;
    d1_ready = r1;
    d2_ready = r2;
  endtask

  initial begin
    logic held;
    rst = 1'b1;
    drive(1'b0, 2'b00, '0);
    set_ready(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) m_data[n] = '0;
    m_err = 1'b0;
    m_cnt = '0;
    cycle();
    cycle();
    chk("rst_d0_valid", d0_valid, 1'b0);
    chk("rst_drop_cnt", drop_cnt, 16'd0);
    rst = 1'b0;

    // Single word to d0.
    set_ready(1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 64'hA5A5_0000_0000_0001);
    cycle();
    chk("first_d0", d0_data, 64'hA5A5_0000_0000_0001);
    drive(1'b0, 2'b00, '0);
    cycle();

    // Back-to-back to d0, d1, d2.
    set_ready(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'(i), 64'h1000 + 64'(i));
      cycle();
    end
    drive(1'b0, 2'b00, '0);
    cycle();
    cycle();

    // Backpressure on d1; second word waits, then lands once d1 drains.
    set_ready(1'b1, 1'b0, 1'b1);
    drive(1'b1, 2'b01, 64'hB1);
    cycle();
    drive(1'b1, 2'b01, 64'hB2);
    cycle();
    cycle();
    chk("bp_d1_held", d1_data, 64'hB1);
    d1_ready = 1'b1;
    cycle();
    chk("bp_d1_second", d1_data, 64'hB2);
    d1_ready = 1'b0;
    drive(1'b1, 2'b01, 64'hB3);
    cycle();
    drive(1'b1, 2'b10, 64'hC1);
    cycle();
    chk("bp_d2_passes", d2_valid, 1'b1);
    d1_ready = 1'b1;
    drive(1'b0, 2'b00, '0);
    cycle();
    cycle();

    // Four illegal selects.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b11, 64'hDEAD_0000 + 64'(i));
      cycle();
    end
    drive(1'b0, 2'b00, '0);
    cycle();
    chk("drop4", drop_cnt, 16'd4);

    // Same-slot fill and drain on d2.
    d2_ready = 1'b0;
    drive(1'b1, 2'b10, 64'hE1);
    cycle();
    d2_ready = 1'b1;
    drive(1'b1, 2'b10, 64'hE2);
    cycle();
    chk("refill_d2_valid", d2_valid, 1'b1);
    chk("refill_d2_data", d2_data, 64'hE2);
    drive(1'b0, 2'b00, '0);
    cycle();

    // Mid-operation reset with words buffered and a word on the input.
    set_ready(1'b0, 1'b0, 1'b1);
    drive(1'b1, 2'b00, 64'hF0);
    cycle();
    drive(1'b1, 2'b01, 64'hF1);
    cycle();
    rst = 1'b1;
    drive(1'b1, 2'b00, 64'hF2);
    cycle();
    rst = 1'b0;
    chk("mrst_d0_valid", d0_valid, 1'b0);
    chk("mrst_d1_valid", d1_valid, 1'b0);
    chk("mrst_drop_cnt", drop_cnt, 16'd0);
    drive(1'b0, 2'b00, '0);
    cycle();

    // Randomized traffic; a stalled word is held until accepted.
    held = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!held) drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                       {$urandom, $urandom});
      set_ready(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 3) == 0));
      rst = ($urandom_range(0, 299) == 0);
      #1;
      held = in_valid && !in_ready && !rst;
      cycle();
    end
    rst = 1'b0;

    // Saturate the drop counter.
    drive(1'b1, 2'b11, 64'h5A);
    for (int i = 0; i < 65540; i++) cycle();
    chk("drop_sat", drop_cnt, 16'hFFFF);
    drive(1'b0, 2'b00, '0);
    cycle();
    chk("drop_sat_hold", drop_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
